// File: rtl/dcache_data_sequencer_if.sv
// Bundle of every handshake/bus signal around the D-cache data sequencer:
// CPU word port, refill beat port, victim beat port, data-array port and an
// FSM state probe. The slave modport is the sequencer itself; the master
// modport is its environment (cache controller, AXI path and data array).
interface dcache_data_sequencer_if #(
  parameter int INDEX_W = 5,
  parameter int LINE_W  = 128,
  parameter int WORD_W  = 32,
  parameter int OFF_W   = 2
);
  // Handshakes: a transfer happens on a cycle where valid && ready are both
  // high; valid never depends on ready; a producer holds its payload stable
  // while valid is high and ready is low.

  // CPU word access
  logic                 cpu_req_valid;
  logic                 cpu_req_ready;
  logic                 cpu_req_we;
  logic [INDEX_W-1:0]   cpu_req_index;
  logic [OFF_W-1:0]     cpu_req_off;
  logic                 cpu_req_way;
  logic [WORD_W-1:0]    cpu_req_wdata;
  logic [WORD_W/8-1:0]  cpu_req_wstrb;
  logic                 cpu_rsp_valid;
  logic [WORD_W-1:0]    cpu_rsp_rdata;

  // Line refill
  logic                 fill_start;
  logic [INDEX_W-1:0]   fill_index;
  logic                 fill_way;
  logic [OFF_W-1:0]     fill_off;
  logic                 fill_beat_valid;
  logic [WORD_W-1:0]    fill_beat_data;
  logic                 fill_beat_ready;
  logic                 fill_done;

  // Victim read-out
  logic                 evict_start;
  logic [INDEX_W-1:0]   evict_index;
  logic                 evict_way;
  logic                 evict_beat_valid;
  logic [WORD_W-1:0]    evict_beat_data;
  logic                 evict_beat_last;
  logic                 evict_beat_ready;

  logic                 busy;
  logic [2:0]           dbg_state;

  // Data array port (CEB/WEB/BWEB active-low)
  logic [INDEX_W-1:0]   da_A;
  logic [LINE_W-1:0]    da_DI;
  logic                 da_WEB;
  logic [LINE_W-1:0]    da_BWEB;
  logic                 da_CEB;
  logic                 da_WAY;
  logic [LINE_W-1:0]    da_DO;

  modport slave (
    input  cpu_req_valid, cpu_req_we, cpu_req_index, cpu_req_off, cpu_req_way,
           cpu_req_wdata, cpu_req_wstrb,
    output cpu_req_ready, cpu_rsp_valid, cpu_rsp_rdata,
    input  fill_start, fill_index, fill_way, fill_off, fill_beat_valid, fill_beat_data,
    output fill_beat_ready, fill_done,
    input  evict_start, evict_index, evict_way, evict_beat_ready,
    output evict_beat_valid, evict_beat_data, evict_beat_last,
    output busy, dbg_state,
    output da_A, da_DI, da_WEB, da_BWEB, da_CEB, da_WAY,
    input  da_DO
  );

  modport master (
    output cpu_req_valid, cpu_req_we, cpu_req_index, cpu_req_off, cpu_req_way,
           cpu_req_wdata, cpu_req_wstrb,
    input  cpu_req_ready, cpu_rsp_valid, cpu_rsp_rdata,
    output fill_start, fill_index, fill_way, fill_off, fill_beat_valid, fill_beat_data,
    input  fill_beat_ready, fill_done,
    output evict_start, evict_index, evict_way, evict_beat_ready,
    input  evict_beat_valid, evict_beat_data, evict_beat_last,
    input  busy, dbg_state,
    input  da_A, da_DI, da_WEB, da_BWEB, da_CEB, da_WAY,
    output da_DO
  );
endinterface

// File: rtl/dcache_data_sequencer.sv
// D-cache data-array sequencer: serialises CPU word reads/writes, 4-beat
// refill writes and victim line read-out onto the single 2-way data-array
// port. Covers the 1-cycle SRAM read latency and 32-bit lane masking.
// Optional feature: define DCACHE_CRIT_WORD_FIRST_EN to start refills at the
// critical word offset (fill_off) and wrap; otherwise refills start at word 0.
module dcache_data_sequencer #(
  parameter int INDEX_W = 5,
  parameter int LINE_W  = 128,
  parameter int WORD_W  = 32
) (
  input logic                    clk,
  input logic                    rst,
  dcache_data_sequencer_if.slave bus
);

  localparam int WORDS = LINE_W / WORD_W;
  localparam int OFF_W = $clog2(WORDS);
  localparam int BYTES = WORD_W / 8;
  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FILL   = 3'd1,
    S_EV_RD  = 3'd2,
    S_EV_CAP = 3'd3,
    S_EV_OUT = 3'd4
  } state_t;

  state_t             state_q;
  logic [INDEX_W-1:0] fill_index_q;
  logic               fill_way_q;
  logic [OFF_W-1:0]   ptr_q;        // array word the next refill beat lands in
  logic [OFF_W-1:0]   cnt_q;        // beats done in the current fill / evict
  logic [INDEX_W-1:0] ev_index_q;
  logic               ev_way_q;
  logic [LINE_W-1:0]  buf_q;        // captured victim line
  logic               rsp_valid_q;
  logic               rsp_rd_q;     // pending response is a read
  logic [OFF_W-1:0]   off_q;        // word offset of the pending response
  logic               fill_done_q;

  logic               cpu_accept;
  logic               fill_fire;
  logic [WORD_W-1:0]  lane_mask;

`ifdef DCACHE_CRIT_WORD_FIRST_EN
  logic [OFF_W-1:0]   fill_ptr_init;
  assign fill_ptr_init = bus.fill_off;
`else
  logic [OFF_W-1:0]   fill_ptr_init;
  logic               unused_fill_off;
  assign fill_ptr_init   = '0;
  assign unused_fill_off = ^bus.fill_off;
`endif

  // Evict and fill starts outrank the CPU, so they hold off acceptance.
  assign bus.cpu_req_ready = !rst && (state_q == S_IDLE) && !bus.evict_start && !bus.fill_start;
  assign cpu_accept        = bus.cpu_req_valid && bus.cpu_req_ready;
  assign fill_fire         = (state_q == S_FILL) && bus.fill_beat_valid;

  assign bus.cpu_rsp_valid    = rsp_valid_q;
  assign bus.cpu_rsp_rdata    = rsp_rd_q ? bus.da_DO[off_q*WORD_W +: WORD_W] : '0;
  assign bus.fill_beat_ready  = (state_q == S_FILL);
  assign bus.fill_done        = fill_done_q;
  assign bus.evict_beat_valid = (state_q == S_EV_OUT);
  assign bus.evict_beat_data  = buf_q[cnt_q*WORD_W +: WORD_W];
  assign bus.evict_beat_last  = (state_q == S_EV_OUT) && (cnt_q == LAST_WORD);
  assign bus.busy             = (state_q != S_IDLE);
  assign bus.dbg_state        = state_q;

  // Active-low per-bit write enables for the addressed lane from byte strobes.
  always_comb begin
    lane_mask = '1;
    for (int b = 0; b < BYTES; b++) begin
      lane_mask[b*8 +: 8] = {8{~bus.cpu_req_wstrb[b]}};
    end
  end

  // Drive the array port: at most one access source per cycle, idle otherwise.
  always_comb begin
    bus.da_A    = '0;
    bus.da_WAY  = 1'b0;
    bus.da_CEB  = 1'b1;
    bus.da_WEB  = 1'b1;
    bus.da_BWEB = '1;
    bus.da_DI   = '0;
    if (cpu_accept) begin
      bus.da_A   = bus.cpu_req_index;
      bus.da_WAY = bus.cpu_req_way;
      if (!bus.cpu_req_we) begin
        bus.da_CEB = 1'b0;
      end else if (|bus.cpu_req_wstrb) begin
        // An all-zero strobe write is answered but never touches the array.
        bus.da_CEB = 1'b0;
        bus.da_WEB = 1'b0;
        bus.da_DI  = {WORDS{bus.cpu_req_wdata}};
        bus.da_BWEB[bus.cpu_req_off*WORD_W +: WORD_W] = lane_mask;
      end
    end else if (fill_fire) begin
      bus.da_A   = fill_index_q;
      bus.da_WAY = fill_way_q;
      bus.da_CEB = 1'b0;
      bus.da_WEB = 1'b0;
      bus.da_DI[ptr_q*WORD_W +: WORD_W]   = bus.fill_beat_data;
      bus.da_BWEB[ptr_q*WORD_W +: WORD_W] = '0;
    end else if (state_q == S_EV_RD) begin
      bus.da_A   = ev_index_q;
      bus.da_WAY = ev_way_q;
      bus.da_CEB = 1'b0;
    end
  end

  // Sequencer FSM with its counters, latched targets and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      fill_index_q <= '0;
      fill_way_q   <= 1'b0;
      ptr_q        <= '0;
      cnt_q        <= '0;
      ev_index_q   <= '0;
      ev_way_q     <= 1'b0;
      buf_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rd_q     <= 1'b0;
      off_q        <= '0;
      fill_done_q  <= 1'b0;
    end else begin
      rsp_valid_q <= cpu_accept;
      rsp_rd_q    <= cpu_accept && !bus.cpu_req_we;
      if (cpu_accept) begin
        off_q <= bus.cpu_req_off;
      end
      fill_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.evict_start) begin
            ev_index_q <= bus.evict_index;
            ev_way_q   <= bus.evict_way;
            cnt_q      <= '0;
            state_q    <= S_EV_RD;
          end else if (bus.fill_start) begin
            fill_index_q <= bus.fill_index;
            fill_way_q   <= bus.fill_way;
            ptr_q        <= fill_ptr_init;
            cnt_q        <= '0;
            state_q      <= S_FILL;
          end
        end
        S_FILL: begin
          if (bus.fill_beat_valid) begin
            ptr_q <= ptr_q + 1'b1;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST_WORD) begin
              fill_done_q <= 1'b1;
              state_q     <= S_IDLE;
            end
          end
        end
        S_EV_RD: begin
          state_q <= S_EV_CAP;
        end
        S_EV_CAP: begin
          buf_q   <= bus.da_DO;
          state_q <= S_EV_OUT;
        end
        S_EV_OUT: begin
          if (bus.evict_beat_ready) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST_WORD) begin
              state_q <= S_IDLE;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_data_sequencer.sv
// Directed bench for dcache_data_sequencer with a behavioural 2-way data
// array (1-cycle read latency, active-low bit write enables).
module tb_dcache_data_sequencer;

  logic clk;
  logic rst;
  logic mem_init;
  int   n_checks;
  int   n_errors;

  dcache_data_sequencer_if bus ();

  dcache_data_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data array model
  logic [127:0] mem [2][32];
  logic [127:0] do_q;
  assign bus.da_DO = do_q;

  function automatic logic [31:0] word_init(input int w, input int i, input int k);
    return {8'(w), 8'(i), 8'(k), 8'h5A};
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      do_q <= '0;
      for (int w = 0; w < 2; w++)
        for (int i = 0; i < 32; i++)
          for (int k = 0; k < 4; k++)
            mem[w][i][k*32 +: 32] <= word_init(w, i, k);
    end else if (!bus.da_CEB) begin
      if (!bus.da_WEB)
        mem[bus.da_WAY][bus.da_A] <= (mem[bus.da_WAY][bus.da_A] & bus.da_BWEB) |
                                     (bus.da_DI & ~bus.da_BWEB);
      else
        do_q <= mem[bus.da_WAY][bus.da_A];
    end
  end

  // Checker
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver tasks
  task automatic cpu_drive(input logic we, input int idx, input int off, input logic way,
                           input logic [31:0] wdata, input logic [3:0] wstrb);
    bus.cpu_req_valid = 1'b1;
    bus.cpu_req_we    = we;
    bus.cpu_req_index = 5'(idx);
    bus.cpu_req_off   = 2'(off);
    bus.cpu_req_way   = way;
    bus.cpu_req_wdata = wdata;
    bus.cpu_req_wstrb = wstrb;
  endtask

  task automatic cpu_idle();
    bus.cpu_req_valid = 1'b0;
    bus.cpu_req_we    = 1'b0;
    bus.cpu_req_wstrb = 4'h0;
  endtask

  logic [31:0]  exp_line [4];
  logic [31:0]  beat;
  logic [127:0] bweb_exp;
  int           start_w;
  int           ev_beat;
  logic         rdy_pat [6];

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    mem_init = 1'b1;
    cpu_idle();
    bus.cpu_req_index    = '0;
    bus.cpu_req_off      = '0;
    bus.cpu_req_way      = 1'b0;
    bus.cpu_req_wdata    = '0;
    bus.fill_start       = 1'b0;
    bus.fill_index       = '0;
    bus.fill_way         = 1'b0;
    bus.fill_off         = '0;
    bus.fill_beat_valid  = 1'b0;
    bus.fill_beat_data   = '0;
    bus.evict_start      = 1'b0;
    bus.evict_index      = '0;
    bus.evict_way        = 1'b0;
    bus.evict_beat_ready = 1'b0;

    // Reset state
    #2;
    check("rst_busy", bus.busy, 1'b0);
    check("rst_ceb", bus.da_CEB, 1'b1);
    check("rst_web", bus.da_WEB, 1'b1);
    check("rst_bweb", bus.da_BWEB, {128{1'b1}});
    check("rst_di", bus.da_DI, 128'h0);
    check("rst_a_way", {bus.da_A, bus.da_WAY}, 6'h0);
    check("rst_ready", bus.cpu_req_ready, 1'b0);
    tick();
    mem_init = 1'b0;
    tick();
    check("rst_rsp_valid", bus.cpu_rsp_valid, 1'b0);
    check("rst_rsp_rdata", bus.cpu_rsp_rdata, 32'h0);
    check("rst_fill_done", bus.fill_done, 1'b0);
    check("rst_ev_valid", {bus.evict_beat_valid, bus.evict_beat_last}, 2'b00);
    check("rst_ev_data", bus.evict_beat_data, 32'h0);
    check("rst_fill_ready", bus.fill_beat_ready, 1'b0);
    rst = 1'b0;
    #1;
    check("idle_ready", bus.cpu_req_ready, 1'b1);

    // T2: partial write then read of the same word in the next cycle
    cpu_drive(1'b1, 3, 1, 1'b1, 32'hDEADBEEF, 4'b0011);
    #1;
    check("wr_ceb", bus.da_CEB, 1'b0);
    check("wr_web", bus.da_WEB, 1'b0);
    check("wr_a_way", {bus.da_A, bus.da_WAY}, {5'd3, 1'b1});
    check("wr_di", bus.da_DI, {4{32'hDEADBEEF}});
    check("wr_bweb", bus.da_BWEB, {32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFF0000, 32'hFFFFFFFF});
    tick();
    check("wr_rsp_valid", bus.cpu_rsp_valid, 1'b1);
    check("wr_rsp_rdata", bus.cpu_rsp_rdata, 32'h0);
    cpu_drive(1'b0, 3, 1, 1'b1, 32'h0, 4'h0);
    #1;
    check("rd_ceb_web", {bus.da_CEB, bus.da_WEB}, 2'b01);
    tick();
    check("raw_rsp_valid", bus.cpu_rsp_valid, 1'b1);
    check("raw_rsp_rdata", bus.cpu_rsp_rdata, 32'h0103BEEF);

    // Zero-strobe write: no array access, response still given, word unchanged
    cpu_drive(1'b1, 3, 2, 1'b1, 32'h12345678, 4'b0000);
    #1;
    check("wz_ceb", bus.da_CEB, 1'b1);
    tick();
    check("wz_rsp", {bus.cpu_rsp_valid, bus.cpu_rsp_rdata}, {1'b1, 32'h0});
    cpu_drive(1'b0, 3, 2, 1'b1, 32'h0, 4'h0);
    tick();
    check("wz_readback", bus.cpu_rsp_rdata, 32'h0103025A);
    cpu_idle();
    tick();
    check("rsp_idle", bus.cpu_rsp_valid, 1'b0);

    // T6: four back-to-back reads alternating ways
    for (int i = 0; i < 4; i++) begin
      cpu_drive(1'b0, 5, i, 1'(i % 2), 32'h0, 4'h0);
      tick();
      check($sformatf("b2b_valid%0d", i), bus.cpu_rsp_valid, 1'b1);
      check($sformatf("b2b_rdata%0d", i), bus.cpu_rsp_rdata, word_init(i % 2, 5, i));
    end
    cpu_idle();
    tick();
    check("b2b_end", bus.cpu_rsp_valid, 1'b0);

    // T3: refill idx 7 way 0 with critical offset 2
`ifdef DCACHE_CRIT_WORD_FIRST_EN
    start_w = 2;
`else
    start_w = 0;
`endif
    for (int k = 0; k < 4; k++) exp_line[(start_w + k) % 4] = 32'hCAFE00A0 + 32'(k);
    bus.fill_start = 1'b1;
    bus.fill_index = 5'd7;
    bus.fill_way   = 1'b0;
    bus.fill_off   = 2'd2;
    #1;
    check("fill_start_ready", bus.cpu_req_ready, 1'b0);
    tick();
    bus.fill_start = 1'b0;
    check("fill_busy", bus.busy, 1'b1);
    check("fill_beat_ready", bus.fill_beat_ready, 1'b1);
    for (int k = 0; k < 4; k++) begin
      beat = 32'hCAFE00A0 + 32'(k);
      bus.fill_beat_valid = 1'b1;
      bus.fill_beat_data  = beat;
      #1;
      check($sformatf("fill_ce_we%0d", k), {bus.da_CEB, bus.da_WEB}, 2'b00);
      check($sformatf("fill_di%0d", k), bus.da_DI[((start_w + k) % 4)*32 +: 32], beat);
      bweb_exp = {128{1'b1}};
      bweb_exp[((start_w + k) % 4)*32 +: 32] = 32'h0;
      check($sformatf("fill_bweb%0d", k), bus.da_BWEB, bweb_exp);
      tick();
      bus.fill_beat_valid = 1'b0;
      if (k == 1) begin
        #1;
        check("fill_gap_ceb", bus.da_CEB, 1'b1);
        check("fill_gap_done", bus.fill_done, 1'b0);
        tick();
      end
    end
    check("fill_done_pulse", bus.fill_done, 1'b1);
    check("fill_done_busy", bus.busy, 1'b0);
    tick();
    check("fill_done_clear", bus.fill_done, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cpu_drive(1'b0, 7, k, 1'b0, 32'h0, 4'h0);
      tick();
      check($sformatf("fill_rd%0d", k), bus.cpu_rsp_rdata, exp_line[k]);
    end
    cpu_idle();

    // T5 + T4: simultaneous starts, evict wins; stalled victim read-out
    bus.evict_start = 1'b1;
    bus.evict_index = 5'd7;
    bus.evict_way   = 1'b0;
    bus.fill_start  = 1'b1;
    bus.fill_index  = 5'd9;
    cpu_drive(1'b0, 1, 0, 1'b0, 32'h0, 4'h0);
    #1;
    check("pri_ready", bus.cpu_req_ready, 1'b0);
    check("pri_ceb", bus.da_CEB, 1'b1);
    tick();
    bus.evict_start = 1'b0;
    bus.fill_start  = 1'b0;
    cpu_idle();
    check("ev_rd_state", bus.dbg_state, 3'd2);
    check("ev_rd_ctrl", {bus.da_CEB, bus.da_WEB, bus.da_A, bus.da_WAY}, {1'b0, 1'b1, 5'd7, 1'b0});
    check("pri_no_rsp", bus.cpu_rsp_valid, 1'b0);
    tick();
    check("ev_cap_valid", bus.evict_beat_valid, 1'b0);
    check("ev_cap_ceb", bus.da_CEB, 1'b1);
    tick();
    rdy_pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    ev_beat = 0;
    for (int j = 0; j < 6; j++) begin
      bus.evict_beat_ready = rdy_pat[j];
      #1;
      check($sformatf("ev_valid%0d", j), bus.evict_beat_valid, 1'b1);
      check($sformatf("ev_data%0d", j), bus.evict_beat_data, exp_line[ev_beat]);
      check($sformatf("ev_last%0d", j), bus.evict_beat_last, 1'(ev_beat == 3));
      check($sformatf("ev_ceb%0d", j), bus.da_CEB, 1'b1);
      tick();
      if (rdy_pat[j]) ev_beat++;
    end
    bus.evict_beat_ready = 1'b0;
    check("ev_done_busy", bus.busy, 1'b0);
    check("ev_done_valid", bus.evict_beat_valid, 1'b0);
    check("ev_fill_ignored", bus.fill_beat_ready, 1'b0);

    // T1: reset in the middle of a refill
    bus.fill_start = 1'b1;
    bus.fill_index = 5'd9;
    bus.fill_way   = 1'b1;
    tick();
    bus.fill_start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus.fill_beat_valid = 1'b1;
      bus.fill_beat_data  = 32'h55550000 + 32'(k);
      tick();
    end
    bus.fill_beat_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_busy", bus.busy, 1'b0);
    check("mid_rst_ceb", bus.da_CEB, 1'b1);
    check("mid_rst_bweb", bus.da_BWEB, {128{1'b1}});
    check("mid_rst_fill_ready", bus.fill_beat_ready, 1'b0);
    for (int c = 0; c < 4; c++) begin
      if (c == 2) rst = 1'b0;
      tick();
      check($sformatf("mid_rst_done%0d", c), bus.fill_done, 1'b0);
    end
    check("post_rst_ready", bus.cpu_req_ready, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
